// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arb
// Purpose  : Round-robin arbiter that time-shares one combinational W-bit
//            adder among NREQ requesters and returns results over valid/ready.
// Revision : 1.0
// ============================================================================
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      adder_a,
    output logic [W-1:0]      adder_b,
    input  logic [W-1:0]      adder_sum,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_op   = 2'd1;
    localparam logic [1:0] c_rsp  = 2'd2;
    localparam int         c_sw   = IDW + 1;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;

    logic           w_any;
    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_idx;
    logic [c_sw-1:0] w_sum;
    logic [IDW-1:0] w_next_ptr;
    logic [W-1:0]   w_op_a;
    logic [W-1:0]   w_op_b;
    logic           w_can_accept;
    logic           w_accept;

    // Scan indices ptr, ptr+1, ... with wrap; the first valid one wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + c_sw'(k);
            if (w_sum >= c_sw'(NREQ)) begin
                w_sum = w_sum - c_sw'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_any && req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_op_a = req_a[i*W +: W];
                w_op_b = req_b[i*W +: W];
            end
        end
    end

    assign w_next_ptr = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);

    // Gating with rst_n keeps req_ready low for the whole reset pulse.
    assign w_can_accept = rst_n && ((r_state == c_idle) ||
                                    ((r_state == c_rsp) && rsp_ready));

    always_comb begin
        req_ready = '0;
        if (w_can_accept && w_any) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept  = |(req_valid & req_ready);
    assign rsp_valid = (r_state == c_rsp);
    assign busy      = (r_state == c_op) || (r_state == c_rsp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_idle;
            r_ptr    <= '0;
            r_id     <= '0;
            adder_a  <= '0;
            adder_b  <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            // Adder operands move only on an accept so the adder stays quiet otherwise.
            if (w_accept) begin
                adder_a <= w_op_a;
                adder_b <= w_op_b;
                r_id    <= w_grant;
                r_ptr   <= w_next_ptr;
            end
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_state <= c_op;
                    end
                end
                c_op: begin
                    rsp_data <= adder_sum;
                    rsp_id   <= r_id;
                    r_state  <= c_rsp;
                end
                c_rsp: begin
                    if (rsp_ready) begin
                        r_state <= w_accept ? c_op : c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_share_arb
// Purpose  : Scoreboard bench for adder_share_arb with a carry-in-1 adder.
// Revision : 1.0
// ============================================================================
module tb_adder_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [W-1:0]      adder_a;
    logic [W-1:0]      adder_b;
    logic [W-1:0]      adder_sum;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [W-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    typedef struct packed {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    adder_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_sum (adder_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // Shared adder with carry-in tied high.
    assign adder_sum = adder_a + adder_b + 16'd1;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Present one request, wait for its grant, then withdraw it after the accept edge.
    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_d);
        int n;
        set_ops(i, a, b);
        req_valid[i] = 1'b1;
        sb.push_back('{d: exp_d, id: IDW'(i)});
        n = 0;
        #1;
        while (!req_ready[i] && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("grant_timeout", {31'd0, n >= 50}, 32'd0);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, n >= 50}, 32'd0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: every response handshake pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got data %h id %0d expected none", rsp_data, rsp_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", {16'd0, rsp_data}, {16'd0, e.d});
                check("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_adder_a", {16'd0, adder_a}, 32'd0);
        check("rst_adder_b", {16'd0, adder_b}, 32'd0);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2
        rsp_ready = 1'b1;
        set_ops(2, 16'h0003, 16'h0004);
        req_valid = 4'b0100;
        sb.push_back('{d: 16'h0008, id: 2'd2});
        #1 check("single_ready_c0", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        #1;
        check("single_busy_c1", {31'd0, busy}, 32'd1);
        check("single_rv_c1", {31'd0, rsp_valid}, 32'd0);
        check("single_adder_a", {16'd0, adder_a}, 32'h3);
        check("single_adder_b", {16'd0, adder_b}, 32'h4);
        tick();
        #1;
        check("single_rv_c2", {31'd0, rsp_valid}, 32'd1);
        check("single_data_c2", {16'd0, rsp_data}, 32'h8);
        check("single_id_c2", {30'd0, rsp_id}, 32'd2);
        tick();
        #1;
        check("single_busy_c3", {31'd0, busy}, 32'd0);
        tick();

        // Wrap-around of the 16-bit result
        issue(0, 16'hFFFF, 16'h0000, 16'h0000);
        wait_idle();
        issue(0, 16'hFFFE, 16'h0001, 16'h0000);
        wait_idle();

        // Round-robin after a reset that must return the pointer to 0
        reset_dut();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i), 16'h0010);
        sb.push_back('{d: 16'h0011, id: 2'd0});
        sb.push_back('{d: 16'h0012, id: 2'd1});
        sb.push_back('{d: 16'h0013, id: 2'd2});
        sb.push_back('{d: 16'h0014, id: 2'd3});
        sb.push_back('{d: 16'h0011, id: 2'd0});
        req_valid = 4'hF;
        #1 check("rr_ready_c0", {28'd0, req_ready}, 32'h1);
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c == 9) req_valid = '0;
            #1;
            check("rr_rsp_valid", {31'd0, rsp_valid}, {31'd0, (c % 2) == 0});
            tick();
        end
        check("rr_busy_end", {31'd0, busy}, 32'd0);

        // Backpressure while requester 1 waits
        issue(0, 16'h0005, 16'h0006, 16'h000C);
        rsp_ready = 1'b0;
        set_ops(1, 16'h0100, 16'h0200);
        req_valid = 4'b0010;
        sb.push_back('{d: 16'h0301, id: 2'd1});
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", {16'd0, rsp_data}, 32'h000C);
            check("bp_rsp_id", {30'd0, rsp_id}, 32'd0);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
            check("bp_adder_a", {16'd0, adder_a}, 32'h0005);
            check("bp_adder_b", {16'd0, adder_b}, 32'h0006);
            tick();
        end
        rsp_ready = 1'b1;
        #1 check("bp_release_ready", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        #1;
        check("bp_op_busy", {31'd0, busy}, 32'd1);
        check("bp_op_adder_a", {16'd0, adder_a}, 32'h0100);
        check("bp_op_adder_b", {16'd0, adder_b}, 32'h0200);
        tick();
        wait_idle();

        // Idle hold: operands and pointer untouched for 10 idle cycles
        issue(1, 16'h1234, 16'h0F0F, 16'h2144);
        wait_idle();
        for (int c = 0; c < 10; c++) begin
            check("idle_adder_a", {16'd0, adder_a}, 32'h1234);
            check("idle_adder_b", {16'd0, adder_b}, 32'h0F0F);
            check("idle_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'h0003, 16'h0004);
        req_valid = 4'hF;
        sb.push_back('{d: 16'h0008, id: 2'd2});
        #1 check("idle_ptr_grant", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        wait_idle();

        // Asynchronous reset while in OP
        set_ops(1, 16'h0AAA, 16'h0555);
        req_valid = 4'b0010;
        #1 check("rmid_ready", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        #1 check("rmid_in_op", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rmid_req_ready", {28'd0, req_ready}, 32'd0);
        check("rmid_adder_a", {16'd0, adder_a}, 32'd0);
        check("rmid_adder_b", {16'd0, adder_b}, 32'd0);
        check("rmid_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rmid_rsp_id", {30'd0, rsp_id}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(3, 16'h0007, 16'h0008, 16'h0010);
        wait_idle();
        tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
